// File: rtl/fsm_par_mux_pkg.sv
// rtl/fsm_par_mux_pkg.sv - shared types, constants and helpers for the parallel channel mux
package fsm_par_mux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FIRST_PKT = 3'd1,
        ST_REG_PKT   = 3'd2,
        ST_F_ERR     = 3'd3,
        ST_SEQ_ERR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_GOOD    = 2'd0,
        CLS_HDR_BAD = 2'd1,
        CLS_SEQ_BAD = 2'd2
    } cls_t;

    localparam logic [3:0] HDR_VALID = 4'hF;
    localparam logic [7:0] ERR_MAX   = 8'hFF;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - round-robin one-hot arbiter, search starts after the last granted channel
module rr_arbiter_n
    import fsm_par_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] last_grant;
    logic            found;

    // Two ascending passes: channels above last_grant first, then wrap to the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && req[j] && (j > int'(last_grant))) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = CH_W'(j);
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && req[j] && (j <= int'(last_grant))) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = CH_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/fsm_par_mux_n.sv
// rtl/fsm_par_mux_n.sv - N-channel round-robin mux with header/sequence checking FSM
module fsm_par_mux_n
    import fsm_par_mux_pkg::*;
#(
    parameter int BUS_WIDTH   = 16,
    parameter int NUM_CH      = 4,
    parameter int SEQ_W       = 4,
    parameter bit DROP_ON_ERR = 1'b1,
    localparam int CH_W = ch_w(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH*BUS_WIDTH-1:0] bus_data_in,
    input  logic [NUM_CH-1:0]           valid_in,
    output logic [NUM_CH-1:0]           ready_out,
    output logic [BUS_WIDTH-1:0]        bus_data_out,
    output logic                        valid_out,
    output logic [CH_W-1:0]             ch_out,
    output logic                        err_flag,
    output logic [2:0]                  state,
    output logic [2:0]                  nxt_state,
    output logic                        error,
    output logic [7:0]                  err_count
);

    state_t             st_q, st_d;
    cls_t               cls;
    logic [SEQ_W-1:0]   exp_seq [NUM_CH];
    logic [NUM_CH-1:0]  grant;
    logic [CH_W-1:0]    gidx;
    logic               xfer, in_err, bad, fwd, fwd_err;
    logic [BUS_WIDTH-1:0] word;
    logic [SEQ_W-1:0]   seq, exp_cur;

    rr_arbiter_n #(.NUM_CH(NUM_CH)) u_arb (
        .clk      (clk),
        .rst_n    (reset),
        .req      (valid_in),
        .advance  (xfer),
        .grant    (grant),
        .grant_idx(gidx)
    );

    assign ready_out = grant & {NUM_CH{reset}};
    assign xfer      = |(ready_out & valid_in);
    assign state     = st_q;
    assign nxt_state = st_d;
    assign in_err    = (st_q == ST_F_ERR) || (st_q == ST_SEQ_ERR);
    assign seq       = word[BUS_WIDTH-5 -: SEQ_W];

    always_comb begin
        word    = '0;
        exp_cur = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (grant[j]) begin
                word    = bus_data_in[j*BUS_WIDTH +: BUS_WIDTH];
                exp_cur = exp_seq[j];
            end
        end
    end

    // In an error state any well-headed word resynchronises the channel.
    always_comb begin
        cls = CLS_GOOD;
        if (word[BUS_WIDTH-1 -: 4] != HDR_VALID) begin
            cls = CLS_HDR_BAD;
        end else if (!in_err && (seq != exp_cur)) begin
            cls = CLS_SEQ_BAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q  <= ST_IDLE;
            error <= 1'b0;
        end else begin
            st_q  <= st_d;
            error <= (st_d == ST_F_ERR) || (st_d == ST_SEQ_ERR);
        end
    end

    always_comb begin
        st_d = st_q;
        if (xfer) begin
            case (cls)
                CLS_GOOD:    st_d = ((st_q == ST_FIRST_PKT) || (st_q == ST_REG_PKT)) ? ST_REG_PKT : ST_FIRST_PKT;
                CLS_HDR_BAD: st_d = ST_F_ERR;
                default:     st_d = ST_SEQ_ERR;
            endcase
        end
    end

    always_comb begin
        bad     = xfer && (cls != CLS_GOOD);
        fwd     = xfer && ((cls == CLS_GOOD) || !DROP_ON_ERR);
        fwd_err = bad && !DROP_ON_ERR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < NUM_CH; j++) exp_seq[j] <= '0;
            bus_data_out <= '0;
            valid_out    <= 1'b0;
            ch_out       <= '0;
            err_flag     <= 1'b0;
            err_count    <= '0;
        end else begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (xfer && (cls == CLS_GOOD) && grant[j]) exp_seq[j] <= seq + SEQ_W'(1);
            end
            valid_out <= fwd;
            err_flag  <= fwd_err;
            if (fwd) begin
                bus_data_out <= word;
                ch_out       <= gidx;
            end
            if (bad && (err_count != ERR_MAX)) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fsm_par_mux_n.sv
// tb/tb_fsm_par_mux_n.sv - scoreboard bench for fsm_par_mux_n (drop and forward-on-error instances)
module tb_fsm_par_mux_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] w [4];
    logic [3:0]  valid_in = '0;
    logic [63:0] bus_data_in;
    logic [3:0]  ready_out;
    logic [15:0] bus_data_out;
    logic        valid_out, err_flag, error;
    logic [1:0]  ch_out;
    logic [2:0]  state, nxt_state;
    logic [7:0]  err_count;

    logic [63:0] d0_data = '0;
    logic [3:0]  d0_valid = '0;
    logic [3:0]  d0_ready;
    logic [15:0] d0_bus_out;
    logic        d0_valid_out, d0_err_flag, d0_error;
    logic [1:0]  d0_ch_out;
    logic [2:0]  d0_state, d0_nxt_state;
    logic [7:0]  d0_err_count;

    int checks = 0;
    int errors = 0;
    logic [18:0] q  [$];
    logic [18:0] q0 [$];
    logic [18:0] e, e0;
    int seqs [4];

    assign bus_data_in = {w[3], w[2], w[1], w[0]};

    always #5 clk = ~clk;

    fsm_par_mux_n dut (
        .clk(clk), .reset(rst_n), .bus_data_in(bus_data_in), .valid_in(valid_in),
        .ready_out(ready_out), .bus_data_out(bus_data_out), .valid_out(valid_out),
        .ch_out(ch_out), .err_flag(err_flag), .state(state), .nxt_state(nxt_state),
        .error(error), .err_count(err_count)
    );

    fsm_par_mux_n #(.DROP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .reset(rst_n), .bus_data_in(d0_data), .valid_in(d0_valid),
        .ready_out(d0_ready), .bus_data_out(d0_bus_out), .valid_out(d0_valid_out),
        .ch_out(d0_ch_out), .err_flag(d0_err_flag), .state(d0_state), .nxt_state(d0_nxt_state),
        .error(d0_error), .err_count(d0_err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got %0h expected none", {err_flag, ch_out, bus_data_out});
            end else begin
                e = q.pop_front();
                if ({err_flag, ch_out, bus_data_out} !== e) begin
                    errors++;
                    $display("FAIL out_word: got %0h expected %0h", {err_flag, ch_out, bus_data_out}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (d0_valid_out) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL d0_out_unexpected: got %0h expected none", {d0_err_flag, d0_ch_out, d0_bus_out});
            end else begin
                e0 = q0.pop_front();
                if ({d0_err_flag, d0_ch_out, d0_bus_out} !== e0) begin
                    errors++;
                    $display("FAIL d0_out_word: got %0h expected %0h", {d0_err_flag, d0_ch_out, d0_bus_out}, e0);
                end
            end
        end
    end

    task automatic check_reset_state();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_data_out", 32'(bus_data_out), 32'd0);
        chk("rst_ch_out", 32'(ch_out), 32'd0);
        chk("rst_err_flag", 32'(err_flag), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd0);
        chk("rst_d0_ready", 32'(d0_ready), 32'd0);
    endtask

    task automatic do_reset();
        valid_in = 4'hF;
        d0_valid = 4'hF;
        rst_n    = 1'b0;
        #1;
        check_reset_state();
        q.delete();
        q0.delete();
        @(negedge clk);
        valid_in = '0;
        d0_valid = '0;
        rst_n    = 1'b1;
    endtask

    task automatic send(input int ch, input logic [15:0] word, input bit fwd, input logic [2:0] st);
        @(posedge clk);
        #1;
        w[ch]    = word;
        valid_in = 4'(1 << ch);
        #1;
        chk("ready_single", 32'(ready_out), 32'(1 << ch));
        if (fwd) q.push_back({1'b0, 2'(ch), word});
        @(posedge clk);
        #1;
        valid_in = '0;
        chk("state_after", 32'(state), 32'(st));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < 4; c++) w[c] = 16'h0000;
        valid_in = 4'hF;
        d0_valid = 4'hF;
        #3;
        check_reset_state();
        @(negedge clk);
        valid_in = '0;
        d0_valid = '0;
        rst_n    = 1'b1;

        send(0, 16'hF000, 1'b1, 3'd1);
        send(0, 16'hF100, 1'b1, 3'd2);
        chk("t1_error", 32'(error), 32'd0);

        send(1, 16'hF000, 1'b1, 3'd2);
        send(1, 16'hF200, 1'b0, 3'd4);
        chk("seq_err_error", 32'(error), 32'd1);
        chk("seq_err_count", 32'(err_count), 32'd1);
        send(1, 16'hF300, 1'b1, 3'd1);
        chk("resync_error", 32'(error), 32'd0);
        send(1, 16'hF400, 1'b1, 3'd2);

        // Reset lands while the F200 word is on the output register.
        send(0, 16'hF200, 1'b1, 3'd2);
        do_reset();
        send(0, 16'hF000, 1'b1, 3'd1);
        send(1, 16'hF000, 1'b1, 3'd2);
        send(2, 16'hF000, 1'b1, 3'd2);
        send(3, 16'hF000, 1'b1, 3'd2);
        repeat (2) @(posedge clk);
        #1;

        do_reset();
        for (int c = 0; c < 4; c++) begin
            seqs[c] = 0;
            w[c]    = 16'hF000;
        end
        @(posedge clk);
        #1;
        valid_in = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 32'(ready_out), 32'(1 << (k % 4)));
            q.push_back({1'b0, 2'(k % 4), w[k % 4]});
            @(posedge clk);
            #1;
            seqs[k % 4]++;
            w[k % 4] = 16'hF000 | (16'(seqs[k % 4]) << 8);
        end
        valid_in = '0;
        chk("rr_state", 32'(state), 32'd2);
        chk("rr_error", 32'(error), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        do_reset();
        for (int s = 0; s < 16; s++) send(2, 16'hF000 | (16'(s) << 8), 1'b1, (s == 0) ? 3'd1 : 3'd2);
        send(2, 16'hF000, 1'b1, 3'd2);
        chk("wrap_error", 32'(error), 32'd0);
        chk("wrap_err_count", 32'(err_count), 32'd0);

        @(posedge clk);
        #1;
        d0_data  = '0;
        d0_valid = 4'b0001;
        for (int k = 0; k < 300; k++) q0.push_back({1'b1, 2'd0, 16'h0000});
        @(posedge clk);
        #1;
        chk("d0_state_ferr", 32'(d0_state), 32'd3);
        chk("d0_err_count1", 32'(d0_err_count), 32'd1);
        repeat (299) @(posedge clk);
        #1;
        d0_valid = '0;
        chk("d0_err_sat", 32'(d0_err_count), 32'd255);
        chk("d0_error", 32'(d0_error), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("q_drained", 32'(q.size()), 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_par_mux_n.md
FSM_PAR_MUX_N -- requirements
Module: fsm_par_mux_n

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, word width per channel (min 12).
REQ-002 SHALL have parameter NUM_CH, default 4, number of input channels (2..8).
REQ-003 SHALL have parameter SEQ_W, default 4, sequence-field width (1..BUS_WIDTH-8).
REQ-004 SHALL have parameter DROP_ON_ERR, default 1: 1 = erroneous words dropped, 0 = forwarded with err_flag.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port bus_data_in  input  NUM_CH*BUS_WIDTH  channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
REQ-008 SHALL have port valid_in  input  NUM_CH  per-channel word valid.
REQ-009 SHALL have port ready_out  output  NUM_CH  one-hot grant, combinational, zero or one bit set.
REQ-010 SHALL have port bus_data_out  output  BUS_WIDTH  registered forwarded word.
REQ-011 SHALL have port valid_out  output  1  bus_data_out valid.
REQ-012 SHALL have port ch_out  output  CH_W=max(1,clog2(NUM_CH))  source channel of bus_data_out.
REQ-013 SHALL have port err_flag  output  1  forwarded word was erroneous (DROP_ON_ERR=0 only).
REQ-014 SHALL have ports state / nxt_state  output  3  current and next FSM state.
REQ-015 SHALL have port error  output  1  registered, high in any error state.
REQ-016 SHALL have port err_count  output  8  saturating error counter.

Function
REQ-017 Word format: header = bits [BUS_WIDTH-1 -: 4], valid when 4'hF; seq = bits [BUS_WIDTH-5 -: SEQ_W].
REQ-018 Arbitration: round-robin over valid_in, starting search at last_grant+1; grant only if valid_in set; transfer = ready_out[c] & valid_in[c].
REQ-019 Per-channel expected seq exp[c], reset 0; on good transfer exp[c] := seq+1 modulo 2^SEQ_W (wrap 2^SEQ_W-1 -> 0).
REQ-020 Classification per transfer: HDR_BAD if header != 4'hF; else SEQ_BAD if seq != exp[c]; else GOOD; HDR_BAD has priority when both hold.
REQ-021 States: IDLE=0, FIRST_PKT=1, REG_PKT=2, F_ERR=3, SEQ_ERR=4; no transfer holds state.
REQ-022 Transitions: GOOD -> FIRST_PKT from IDLE/F_ERR/SEQ_ERR, REG_PKT from FIRST_PKT/REG_PKT; HDR_BAD -> F_ERR; SEQ_BAD -> SEQ_ERR from any state.
REQ-023 Resync: transfer with valid header in F_ERR/SEQ_ERR is GOOD regardless of seq; sets exp[c] := seq+1.
REQ-024 Latency: GOOD word appears on bus_data_out/ch_out with valid_out=1 exactly 1 cycle after transfer; valid_out=0 otherwise.
REQ-025 DROP_ON_ERR=1: bad transfers give valid_out=0; DROP_ON_ERR=0: forwarded with err_flag=1.
REQ-026 err_count increments per bad transfer, saturates at 255, never wraps.
REQ-027 Bad transfer on channel c SHALL NOT alter exp[c] nor any other channel's exp.

Reset
REQ-028 reset low SHALL immediately force state=IDLE, all exp=0, last_grant=NUM_CH-1, bus_data_out=0, valid_out=0, ch_out=0, err_flag=0, error=0, err_count=0.
REQ-029 ready_out SHALL be all-zero while reset low; reset mid-transfer discards the word.

Structure
REQ-030 State encodings, header constant 4'hF and CH_W function SHALL live in package fsm_par_mux_pkg.
REQ-031 Arbiter SHALL be sub-module rr_arbiter_n (parameter NUM_CH; req in, one-hot grant out, advance on transfer).

Verification
REQ-032 Reset, ch0 sends 16'hF000 then 16'hF100 -> state IDLE->FIRST_PKT->REG_PKT, outputs 1 cycle later, error=0.
REQ-033 ch1 sends 16'hF000, 16'hF200 -> SEQ_ERR, error=1, err_count=1, second word dropped; then 16'hF300 -> FIRST_PKT, exp[1]=4.
REQ-034 All 4 channels valid continuously, good seqs -> grants cycle 0,1,2,3,0 one per cycle, ch_out follows.
REQ-035 ch2 sends 16 good words seq 0..15 then seq 0 -> all GOOD (wrap), no error.
REQ-036 Word 16'h0000 with DROP_ON_ERR=0 -> F_ERR, valid_out=1, err_flag=1; 300 bad words -> err_count=255.
REQ-037 Assert reset low mid-stream -> all outputs zero same cycle, next 16'hF000 accepted on every channel.
